// File: rtl/rv_div_pkg.sv
// rv_div_pkg: shared definitions for the iterative RISC-V divider.
//   - op_sel encodings (funct3[1:0]): DIV, DIVU, REM, REMU
//   - FSM state encoding: IDLE, CALC, FIX, DONE
//   - XLEN default, taken from the machine-width define RV_XLEN when present
// Optional feature macro used by rv_div: DIV_BYPASS_EN.

`ifndef RV_XLEN
`define RV_XLEN 32
`endif

package rv_div_pkg;

    localparam int unsigned XLEN_DEFAULT = `RV_XLEN;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Signed ops are the even encodings (DIV, REM).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Remainder ops have bit 1 set (REM, REMU).
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/rv_div_step.sv
// rv_div_step: one combinational radix-2 restoring division step.
// Ports:
//   rem_i     - partial remainder (always < divisor)
//   bit_i     - next dividend bit, MSB first
//   divisor_i - divisor magnitude
//   rem_o     - updated partial remainder
//   qbit_o    - quotient bit produced by this step

module rv_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            qbit_o
);

    logic [XLEN:0] shifted_s;

    // The shifted remainder needs XLEN+1 bits: its top bit can be set when
    // the divisor is above 2^(XLEN-1). After a successful subtraction the
    // result is below the divisor, so the low XLEN bits are exact.
    always_comb begin
        shifted_s = {rem_i, bit_i};
        qbit_o    = (shifted_s >= {1'b0, divisor_i}) ? 1'b1 : 1'b0;
        if (qbit_o) begin
            rem_o = shifted_s[XLEN-1:0] - divisor_i;
        end else begin
            rem_o = shifted_s[XLEN-1:0];
        end
    end

endmodule

// File: rtl/rv_div.sv
// rv_div: iterative radix-2 restoring divider for RV M-extension
// DIV/DIVU/REM/REMU. Divides magnitudes one quotient bit per cycle, then
// applies sign fix-up. Divide-by-zero and signed overflow give the
// RISC-V mandated results.
// Ports:
//   clk_i, rst_n_i      - clock, synchronous active-low reset
//   kill_i              - pipeline flush, aborts any operation
//   valid_i / ready_o   - request handshake (ready_o high only in IDLE)
//   op1_i, op2_i        - dividend, divisor
//   op_sel_i            - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   valid_o / ready_i   - result handshake
//   result_o            - quotient or remainder, registered
// Optional feature: define DIV_BYPASS_EN to finish divide-by-zero and signed
// overflow directly at accept (valid_o the cycle after accept).

module rv_div
    import rv_div_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            kill_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [1:0]      op_sel_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    state_e            state_r;
    state_e            state_s;
    logic [CNT_W-1:0]  cnt_r;
    op_sel_e           op_sel_r;
    logic              sign1_r;
    logic              sign2_r;
    // dividend_r shifts left each step; quotient bits enter at the bottom,
    // so after XLEN steps it holds the quotient magnitude.
    logic [XLEN-1:0]   dividend_r;
    logic [XLEN-1:0]   divisor_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   result_r;
    logic              valid_r;

    logic              ready_s;
    logic              accept_s;
    logic              op_signed_s;
    logic [XLEN-1:0]   abs1_s;
    logic [XLEN-1:0]   abs2_s;
    logic [XLEN-1:0]   step_rem_s;
    logic              step_qbit_s;
    logic              bypass_s;
    logic [XLEN-1:0]   bypass_result_s;
    logic              quot_neg_s;
    logic              rem_neg_s;
    logic [XLEN-1:0]   quot_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   fix_result_s;

    rv_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_i     (rem_r),
        .bit_i     (dividend_r[XLEN-1]),
        .divisor_i (divisor_r),
        .rem_o     (step_rem_s),
        .qbit_o    (step_qbit_s)
    );

    // Accept decode and operand magnitudes. The most negative value keeps
    // its bit pattern, which is its correct unsigned magnitude.
    always_comb begin
        accept_s    = valid_i & (state_r == ST_IDLE) & ~kill_i;
        op_signed_s = op_is_signed(op_sel_i);
        if (op_signed_s && op1_i[XLEN-1]) begin
            abs1_s = {XLEN{1'b0}} - op1_i;
        end else begin
            abs1_s = op1_i;
        end
        if (op_signed_s && op2_i[XLEN-1]) begin
            abs2_s = {XLEN{1'b0}} - op2_i;
        end else begin
            abs2_s = op2_i;
        end
    end

`ifdef DIV_BYPASS_EN
    logic div0_s;
    logic ovf_s;

    // Early detection of the two special cases at accept time.
    always_comb begin
        div0_s   = (op2_i == {XLEN{1'b0}});
        ovf_s    = op_signed_s
                   & (op1_i == {1'b1, {(XLEN-1){1'b0}}})
                   & (op2_i == {XLEN{1'b1}});
        bypass_s = div0_s | ovf_s;
        if (div0_s) begin
            bypass_result_s = op_is_rem(op_sel_i) ? op1_i : {XLEN{1'b1}};
        end else if (ovf_s) begin
            bypass_result_s = op_is_rem(op_sel_i) ? {XLEN{1'b0}} : op1_i;
        end else begin
            bypass_result_s = {XLEN{1'b0}};
        end
    end
`else
    assign bypass_s        = 1'b0;
    assign bypass_result_s = {XLEN{1'b0}};
`endif

    // Sign fix-up. A zero divisor leaves the all-ones quotient un-negated;
    // the remainder of a zero divisor is |op1| re-signed, i.e. op1 itself.
    always_comb begin
        quot_neg_s = op_is_signed(op_sel_r) & (sign1_r ^ sign2_r) & (|divisor_r);
        rem_neg_s  = op_is_signed(op_sel_r) & sign1_r;
        if (quot_neg_s) begin
            quot_fix_s = {XLEN{1'b0}} - dividend_r;
        end else begin
            quot_fix_s = dividend_r;
        end
        if (rem_neg_s) begin
            rem_fix_s = {XLEN{1'b0}} - rem_r;
        end else begin
            rem_fix_s = rem_r;
        end
        if (op_is_rem(op_sel_r)) begin
            fix_result_s = rem_fix_s;
        end else begin
            fix_result_s = quot_fix_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; kill_i overrides everything but reset.
    always_comb begin
        state_s = state_r;
        if (kill_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_s = bypass_s ? ST_DONE : ST_CALC;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_s = ST_FIX;
                    end else begin
                        state_s = ST_CALC;
                    end
                end
                ST_FIX:  state_s = ST_DONE;
                ST_DONE: begin
                    if (ready_i) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode: ready depends on state only.
    always_comb begin
        if (state_r == ST_IDLE) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    // Datapath registers: operand capture, iteration, fix-up and result hold.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_r      <= {CNT_W{1'b0}};
            op_sel_r   <= OP_DIV;
            sign1_r    <= 1'b0;
            sign2_r    <= 1'b0;
            dividend_r <= {XLEN{1'b0}};
            divisor_r  <= {XLEN{1'b0}};
            rem_r      <= {XLEN{1'b0}};
            result_r   <= {XLEN{1'b0}};
            valid_r    <= 1'b0;
        end else if (kill_i) begin
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_sel_r   <= op_sel_e'(op_sel_i);
                        sign1_r    <= op_signed_s & op1_i[XLEN-1];
                        sign2_r    <= op_signed_s & op2_i[XLEN-1];
                        dividend_r <= abs1_s;
                        divisor_r  <= abs2_s;
                        rem_r      <= {XLEN{1'b0}};
                        cnt_r      <= CNT_W'(XLEN - 1);
                        if (bypass_s) begin
                            result_r <= bypass_result_s;
                            valid_r  <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    rem_r      <= step_rem_s;
                    dividend_r <= {dividend_r[XLEN-2:0], step_qbit_s};
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    result_r <= fix_result_s;
                    valid_r  <= 1'b1;
                end
                ST_DONE: begin
                    if (ready_i) begin
                        valid_r <= 1'b0;
                    end
                end
                default: valid_r <= 1'b0;
            endcase
        end
    end

    assign ready_o  = ready_s;
    assign valid_o  = valid_r;
    assign result_o = result_r;

endmodule
